rx_packet_queue: RTL and testbench

//  Store-and-forward receive queue: MAC receive beats in, AXI-Stream packets out, one clock domain.

---
 rtl/xg_if_pkg.sv | 16 +
 rtl/sdp_ram.sv | 30 +++
 rtl/rx_packet_queue.sv | 219 +++++++++++++++++++++
 tb/tb_rx_packet_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/xg_if_pkg.sv
// Shared types and defaults for the 10G receive path: write FSM encoding and
// bus-width defaults used by the receive queue.
package xg_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        WAIT_ST = 2'd2,
        DROP    = 2'd3
    } wr_state_t;

    localparam int DATA_WIDTH_DEF    = 64;
    localparam int STRB_W            = DATA_WIDTH_DEF / 8;
    localparam int MAX_PKT_WORDS_DEF = 190;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (one-cycle) synchronous read.
module sdp_ram #(
    parameter int WIDTH      = 73,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rx_packet_queue.sv
// Store-and-forward receive queue: MAC beats are buffered per frame and only
// released to AXI-Stream once the frame's good status has been committed.
module rx_packet_queue
    import xg_if_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH_LOG2    = 9,
    parameter int MAX_PKT_WORDS = MAX_PKT_WORDS_DEF,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic [DATA_WIDTH/8-1:0] rx_data_valid,
    input  logic                    rx_good_frame,
    input  logic                    rx_bad_frame,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic [DATA_WIDTH/8-1:0] tstrb,
    output logic                    tvalid,
    output logic                    tlast,
    input  logic                    tready,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    bad_count,
    output logic [CNT_WIDTH-1:0]    drop_count
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int WW = DATA_WIDTH + SW + 1;
    localparam int CW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    wr_state_t             state;
    logic [DEPTH_LOG2-1:0] wr, commit, rd, free;
    logic [CW-1:0]         wcnt;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [SW-1:0]         hold_strb;
    logic                  beat, st_good, st_bad, st_any;
    logic                  free_ok, store_full, oversize, wr_en, load_hold;
    logic [WW-1:0]         wdata, ram_q;

    logic                  rd_issue_p0, vld_p1, pop;
    logic                  vld_p2, last_p2, skid_vld_p2, skid_last_p2;
    logic [DATA_WIDTH-1:0] data_p2, skid_data_p2;
    logic [SW-1:0]         strb_p2, skid_strb_p2;

    always_comb begin
        beat       = |rx_data_valid;
        st_bad     = rx_bad_frame;
        st_good    = rx_good_frame & ~rx_bad_frame;
        st_any     = rx_good_frame | rx_bad_frame;
        free       = PTR_MAX - (wr - rd);
        free_ok    = 32'(free) >= 32'(MAX_PKT_WORDS);
        store_full = (wr + DEPTH_LOG2'(1)) == rd;
        oversize   = 32'(wcnt) >= 32'(MAX_PKT_WORDS);
        // The held beat is written when the next beat arrives or when the frame ends.
        wr_en      = (state == WRITE) && !store_full && !(beat && oversize);
        load_hold  = beat && (((state == IDLE) && free_ok) || ((state == WRITE) && wr_en));
        wdata      = {~beat, hold_strb, hold_data};
    end

    // Write side: frame assembly, commit and rewind
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr         <= '0;
            commit     <= '0;
            wcnt       <= '0;
            pkt_count  <= '0;
            bad_count  <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        wcnt  <= CW'(1);
                        state <= free_ok ? WRITE : DROP;
                    end
                end
                WRITE: begin
                    if (beat) begin
                        if (wr_en) begin
                            wr   <= wr + DEPTH_LOG2'(1);
                            wcnt <= wcnt + CW'(1);
                        end else begin
                            wr    <= commit;
                            state <= DROP;
                        end
                    end else if (!wr_en) begin
                        wr <= commit;
                        if (st_any) begin
                            drop_count <= sat_inc(drop_count);
                            state      <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else if (st_bad) begin
                        wr        <= commit;
                        bad_count <= sat_inc(bad_count);
                        state     <= IDLE;
                    end else if (st_good) begin
                        wr        <= wr + DEPTH_LOG2'(1);
                        commit    <= wr + DEPTH_LOG2'(1);
                        pkt_count <= sat_inc(pkt_count);
                        state     <= IDLE;
                    end else begin
                        wr    <= wr + DEPTH_LOG2'(1);
                        state <= WAIT_ST;
                    end
                end
                WAIT_ST: begin
                    if (st_bad) begin
                        wr        <= commit;
                        bad_count <= sat_inc(bad_count);
                        state     <= IDLE;
                    end else if (st_good) begin
                        commit    <= wr;
                        pkt_count <= sat_inc(pkt_count);
                        state     <= IDLE;
                    end
                end
                DROP: begin
                    if (st_any) begin
                        drop_count <= sat_inc(drop_count);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_hold) begin
            hold_data <= rx_data;
            hold_strb <= rx_data_valid;
        end
    end

    sdp_ram #(
        .WIDTH      (WW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr),
        .wdata (wdata),
        .re    (rd_issue_p0),
        .raddr (rd),
        .rdata (ram_q)
    );

    // Stage p0: issue a read only if the word in flight will find a free slot
    always_comb begin
        pop         = vld_p2 & tready;
        rd_issue_p0 = (rd != commit) &&
                      (({1'b0, vld_p2} + {1'b0, skid_vld_p2} + {1'b0, vld_p1} - {1'b0, pop}) < 2'd2);
    end

    // Stage p1 -> p2: RAM output lands in the output register or the skid entry
    always_ff @(posedge clk) begin
        if (reset) begin
            rd          <= '0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            skid_vld_p2 <= 1'b0;
            data_p2     <= '0;
            strb_p2     <= '0;
            last_p2     <= 1'b0;
        end else begin
            vld_p1 <= rd_issue_p0;
            if (rd_issue_p0) begin
                rd <= rd + DEPTH_LOG2'(1);
            end
            if (vld_p1) begin
                if (!vld_p2 || pop) begin
                    vld_p2 <= 1'b1;
                    if (skid_vld_p2) begin
                        data_p2 <= skid_data_p2;
                        strb_p2 <= skid_strb_p2;
                        last_p2 <= skid_last_p2;
                    end else begin
                        data_p2 <= ram_q[DATA_WIDTH-1:0];
                        strb_p2 <= ram_q[DATA_WIDTH +: SW];
                        last_p2 <= ram_q[WW-1];
                    end
                end else begin
                    skid_vld_p2 <= 1'b1;
                end
            end else if (pop) begin
                if (skid_vld_p2) begin
                    data_p2     <= skid_data_p2;
                    strb_p2     <= skid_strb_p2;
                    last_p2     <= skid_last_p2;
                    skid_vld_p2 <= 1'b0;
                end else begin
                    vld_p2 <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1 && (skid_vld_p2 || (vld_p2 && !pop))) begin
            skid_data_p2 <= ram_q[DATA_WIDTH-1:0];
            skid_strb_p2 <= ram_q[DATA_WIDTH +: SW];
            skid_last_p2 <= ram_q[WW-1];
        end
    end

    assign tdata  = data_p2;
    assign tstrb  = strb_p2;
    assign tlast  = last_p2;
    assign tvalid = vld_p2;

endmodule

// File: tb/tb_rx_packet_queue.sv
// Directed self-checking bench for rx_packet_queue: frames in, expected beats
// queued by the bench, output beats and counters compared.
module tb_rx_packet_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rx_data;
    logic [7:0]  rx_data_valid;
    logic        rx_good_frame, rx_bad_frame;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tvalid, tlast, tready;
    logic [31:0] pkt_count, bad_count, drop_count;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int status_cyc = 0;
    int first_vld_cyc = -1;
    logic [72:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [72:0] prev_beat;

    rx_packet_queue dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_good_frame (rx_good_frame),
        .rx_bad_frame  (rx_bad_frame),
        .tdata         (tdata),
        .tstrb         (tstrb),
        .tvalid        (tvalid),
        .tlast         (tlast),
        .tready        (tready),
        .pkt_count     (pkt_count),
        .bad_count     (bad_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bmask(input int n);
        logic [7:0] m;
        m = 8'hFF;
        return m >> (8 - n);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        rx_data = '0;
        rx_data_valid = '0;
        rx_good_frame = 1'b0;
        rx_bad_frame = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_frame(input int id, input int n, input int lb, input bit good, input bit pass);
        logic [63:0] d;
        logic [7:0]  v;
        for (int i = 0; i < n; i++) begin
            d = {16'(id), 16'(i), 32'hC0DE_0000 + 32'(i)};
            v = (i == n - 1) ? bmask(lb) : 8'hFF;
            rx_data = d;
            rx_data_valid = v;
            if (pass) exp_q.push_back({(i == n - 1), v, d});
            step();
        end
        rx_data = '0;
        rx_data_valid = '0;
        rx_good_frame = good;
        rx_bad_frame = ~good;
        status_cyc = cyc;
        step();
        rx_good_frame = 1'b0;
        rx_bad_frame = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || tvalid); i++) step();
        chk({tag, "_left"}, 80'(exp_q.size()), 80'd0);
        chk({tag, "_tvalid"}, 80'(tvalid), 80'd0);
    endtask

    task automatic chk_counts(input string tag, input int p, input int b, input int d);
        chk({tag, "_pkt"}, 80'(pkt_count), 80'(p));
        chk({tag, "_bad"}, 80'(bad_count), 80'(b));
        chk({tag, "_drop"}, 80'(drop_count), 80'(d));
    endtask

    // Output monitor: every accepted beat against the expected queue, and
    // stalled beats must stay put until accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_tvalid", 80'(tvalid), 80'd1);
                    chk("stall_beat", 80'({tlast, tstrb, tdata}), 80'(prev_beat));
                end
                if (tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) chk("extra_beat", 80'(exp_q.size()), 80'd1);
                    else chk("beat", 80'({tlast, tstrb, tdata}), 80'(exp_q.pop_front()));
                end
                prev_stall = tvalid && !tready;
                prev_beat = {tlast, tstrb, tdata};
            end
        end
    end

    initial begin
        tready = 1'b1;
        do_reset();
        chk("rst_tvalid", 80'(tvalid), 80'd0);
        chk("rst_tlast", 80'(tlast), 80'd0);
        chk("rst_tstrb", 80'(tstrb), 80'd0);
        chk("rst_tdata", 80'(tdata), 80'd0);
        chk_counts("rst", 0, 0, 0);

        // 1: single 64B good frame, latency from status to first tvalid
        first_vld_cyc = -1;
        send_frame(1, 8, 8, 1'b1, 1'b1);
        drain("t1");
        chk("t1_latency", 80'(first_vld_cyc - status_cyc), 80'd3);
        chk_counts("t1", 1, 0, 0);

        // 2: 61B good frame then 64B bad frame
        do_reset();
        send_frame(2, 8, 5, 1'b1, 1'b1);
        send_frame(3, 8, 8, 1'b0, 1'b0);
        drain("t2");
        chk_counts("t2", 1, 1, 0);

        // 3: two frames held back, then tready toggling
        do_reset();
        tready = 1'b0;
        send_frame(4, 8, 3, 1'b1, 1'b1);
        send_frame(5, 5, 8, 1'b1, 1'b1);
        repeat (10) step();
        chk("t3_stalled_tvalid", 80'(tvalid), 80'd1);
        chk("t3_left", 80'(exp_q.size()), 80'd13);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            tready = ~tready;
            step();
        end
        tready = 1'b1;
        drain("t3");
        chk_counts("t3", 2, 0, 0);

        // 4: store filled with tready=0 until admission fails
        do_reset();
        tready = 1'b0;
        send_frame(10, 128, 8, 1'b1, 1'b1);
        send_frame(11, 128, 8, 1'b1, 1'b1);
        send_frame(12, 128, 8, 1'b1, 1'b1);
        send_frame(13, 8, 8, 1'b1, 1'b0);
        step();
        chk_counts("t4", 3, 0, 1);
        tready = 1'b1;
        drain("t4");

        // 5: oversize frame dropped, next frame passes
        do_reset();
        send_frame(20, 300, 8, 1'b1, 1'b0);
        step();
        chk_counts("t5a", 0, 0, 1);
        send_frame(21, 8, 8, 1'b1, 1'b1);
        drain("t5");
        chk_counts("t5b", 1, 0, 1);

        // 6: reset mid-frame while a committed frame is draining
        do_reset();
        send_frame(30, 8, 8, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rx_data = {16'd31, 16'(i), 32'h0BAD_0000};
            rx_data_valid = 8'hFF;
            step();
        end
        chk("t6_pre_pkt", 80'(pkt_count), 80'd1);
        reset = 1'b1;
        rx_data_valid = '0;
        exp_q.delete();
        step();
        chk("t6_rst_tvalid", 80'(tvalid), 80'd0);
        chk_counts("t6_rst", 0, 0, 0);
        reset = 1'b0;
        repeat (10) step();
        chk("t6_empty_tvalid", 80'(tvalid), 80'd0);
        send_frame(32, 8, 8, 1'b1, 1'b1);
        drain("t6");
        chk_counts("t6", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
